store_buffer: RTL and testbench

Parametrised write buffer between the memory stage and the data memory of the Y86-64 datapath. It generalises the single enabled, resettable storage bit into a DEPTH-entry FIFO of WIDTH-bit store words, each with an address. It drains entries to memory under a valid/ack handshake and forwards the youngest matching store to same-address loads.

---
 rtl/store_buffer_if.sv | 38 +++
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store/load/memory bundle between the memory stage, the store buffer and the data memory.
// The master drives requests and memory acks; the slave (the buffer) drives the rest.
interface store_buffer_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [WIDTH-1:0]  st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [WIDTH-1:0]  ld_data;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_data;
  logic              mem_ack;

  logic [CntW-1:0]   count;
  logic              empty;
  logic              full;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, mem_wr_en, mem_addr, mem_data, count, empty, full
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, mem_wr_en, mem_addr, mem_data, count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// DEPTH-entry FIFO of pending stores that drains to data memory under valid/ack and
// forwards the youngest same-address store to loads combinationally.
module store_buffer #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [WIDTH-1:0]  data_d [DEPTH];
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;

  logic              st_ready;
  logic              mem_wr_en;
  logic              push;
  logic              pop;

  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  ptr_t              fwd_idx;

  // Handshakes are forced low combinationally while reset is held.
  assign st_ready  = reset && !full_q;
  assign mem_wr_en = reset && !empty_q;
  assign push      = bus.st_valid && st_ready;
  assign pop       = mem_wr_en && bus.mem_ack;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.st_addr;
      data_d[tail_q]  = bus.st_data;
      tail_d          = tail_q + ptr_t'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + ptr_t'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.st_ready  = st_ready;
  assign bus.ld_hit    = bus.ld_valid && reset && fwd_hit;
  assign bus.ld_data   = (bus.ld_valid && reset && fwd_hit) ? fwd_data : '0;
  assign bus.mem_wr_en = mem_wr_en;
  assign bus.mem_addr  = empty_q ? '0 : addr_q[head_q];
  assign bus.mem_data  = empty_q ? '0 : data_q[head_q];
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus directed
// literal expectations covering reset, fill, drain, forwarding, wrap and reset mid-drain.
module tb_store_buffer;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;
  ent_t q[$];

  store_buffer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  store_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of pending stores, oldest at the front.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        q.delete();
        chk_en = 1'b1;
      end else begin
        bit do_push;
        bit do_pop;
        do_push = bus.st_valid && (q.size() < DEPTH);
        do_pop  = bus.mem_ack && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({bus.st_addr, bus.st_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic        e_hit;
        logic [63:0] e_ld;
        e_hit = 1'b0;
        e_ld  = '0;
        if (bus.ld_valid && reset) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == bus.ld_addr) begin
              e_hit = 1'b1;
              e_ld  = q[i].d;
            end
          end
        end
        chk("m_st_ready", 64'(bus.st_ready), 64'(reset && (q.size() < DEPTH)));
        chk("m_mem_wr_en", 64'(bus.mem_wr_en), 64'(reset && (q.size() > 0)));
        chk("m_mem_addr", bus.mem_addr, (q.size() > 0) ? q[0].a : 64'd0);
        chk("m_mem_data", bus.mem_data, (q.size() > 0) ? q[0].d : 64'd0);
        chk("m_count", 64'(bus.count), 64'(q.size()));
        chk("m_empty", 64'(bus.empty), 64'(q.size() == 0));
        chk("m_full", 64'(bus.full), 64'(q.size() == DEPTH));
        chk("m_ld_hit", 64'(bus.ld_hit), 64'(e_hit));
        chk("m_ld_data", bus.ld_data, e_ld);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h40;
    bus.st_data  = 64'hDEAD;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 64'h40;
    bus.mem_ack  = 1'b0;

    // Reset held two cycles with a store offered.
    tick();
    tick();
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
    chk("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_ld_hit", 64'(bus.ld_hit), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    bus.ld_valid = 1'b0;
    tick();

    // Fill with no acks.
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = 1'b1;
      bus.st_addr  = 64'h1000 + 64'(8 * i);
      bus.st_data  = 64'hD0 + 64'(i);
      tick();
    end
    bus.st_addr = 64'h2000;
    bus.st_data = 64'hEE;
    #1;
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_st_ready", 64'(bus.st_ready), 64'd0);
    chk("fill_count", 64'(bus.count), 64'd4);
    tick();
    bus.st_valid = 1'b0;
    #1;
    chk("fill_5th_rejected", 64'(bus.count), 64'd4);

    // Drain, one write per cycle.
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_wr_en", 64'(bus.mem_wr_en), 64'd1);
      chk("drain_addr", bus.mem_addr, 64'h1000 + 64'(8 * i));
      chk("drain_data", bus.mem_data, 64'hD0 + 64'(i));
      tick();
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_mem_addr0", bus.mem_addr, 64'd0);

    // Forwarding.
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h100;
    bus.st_data  = 64'h11;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 64'h100;
    #1;
    chk("fwd_same_cycle_miss", 64'(bus.ld_hit), 64'd0);
    tick();
    bus.st_data = 64'h22;
    #1;
    chk("fwd_first_hit_data", bus.ld_data, 64'h11);
    tick();
    bus.st_valid = 1'b0;
    #1;
    chk("fwd_hit", 64'(bus.ld_hit), 64'd1);
    chk("fwd_youngest", bus.ld_data, 64'h22);
    bus.ld_addr = 64'h108;
    #1;
    chk("fwd_miss_hit", 64'(bus.ld_hit), 64'd0);
    chk("fwd_miss_data", bus.ld_data, 64'd0);
    bus.ld_addr = 64'h100;
    bus.mem_ack = 1'b1;
    #1;
    chk("fwd_popping_still_hits", 64'(bus.ld_hit), 64'd1);
    tick();
    tick();
    bus.mem_ack  = 1'b0;
    bus.ld_valid = 1'b0;

    // Two entries with tail crossing zero, then push+pop for six cycles.
    bus.st_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.st_addr = 64'h200 + 64'(8 * i);
      bus.st_data = 64'hA0 + 64'(i);
      tick();
    end
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.st_addr = 64'h210 + 64'(8 * k);
      bus.st_data = 64'hA2 + 64'(k);
      #1;
      chk("wrap_addr", bus.mem_addr, 64'h200 + 64'(8 * k));
      chk("wrap_count", 64'(bus.count), 64'd2);
      tick();
    end
    bus.mem_ack = 1'b0;

    // Reset mid-drain.
    bus.st_addr = 64'h240;
    bus.st_data = 64'hB0;
    tick();
    bus.st_valid = 1'b0;
    #1;
    chk("mid_count3", 64'(bus.count), 64'd3);
    chk("mid_wr_en", 64'(bus.mem_wr_en), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en_low", 64'(bus.mem_wr_en), 64'd0);
    chk("mid_rst_st_ready_low", 64'(bus.st_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_after_count", 64'(bus.count), 64'd0);
    chk("mid_after_wr_en", 64'(bus.mem_wr_en), 64'd0);
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack  = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h300;
    bus.st_data  = 64'h33;
    tick();
    bus.st_valid = 1'b0;
    #1;
    chk("post_rst_addr", bus.mem_addr, 64'h300);
    chk("post_rst_data", bus.mem_data, 64'h33);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("post_rst_empty", 64'(bus.empty), 64'd1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
